// File: rtl/bram_result_drain.sv
// Sequenced read-back of a contiguous BRAM row range, emitted one byte at a time
// over a valid/ready handshake, lowest byte of each row first.
module bram_result_drain #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned DESIGN_SIZE = 32,
  parameter int unsigned AWIDTH      = 11,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [AWIDTH-1:0]             base_addr,
  input  logic [AWIDTH-1:0]             num_rows,
  output logic [AWIDTH-1:0]             bram_addr,
  output logic                          bram_en,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] bram_rdata,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic [AWIDTH-1:0]             rows_drained
);

  localparam int unsigned RowW = DESIGN_SIZE * DWIDTH;
  localparam int unsigned IdxW = (DESIGN_SIZE > 1) ? $clog2(DESIGN_SIZE) : 1;
  localparam int unsigned WcW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] row_ptr_q, row_ptr_d;
  logic [AWIDTH-1:0] remaining_q, remaining_d;
  logic [AWIDTH-1:0] drained_q, drained_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WcW-1:0]    wcnt_q, wcnt_d;
  logic [RowW-1:0]   row_buf_q, row_buf_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      row_ptr_q   <= '0;
      remaining_q <= '0;
      drained_q   <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      row_buf_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_ptr_q   <= row_ptr_d;
      remaining_q <= remaining_d;
      drained_q   <= drained_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      row_buf_q   <= row_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_ptr_d   = row_ptr_q;
    remaining_d = remaining_q;
    drained_d   = drained_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    row_buf_d   = row_buf_q;
    bram_en     = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          row_ptr_d   = base_addr;
          remaining_d = num_rows;
          drained_d   = '0;
          idx_d       = '0;
          state_d     = (num_rows == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        bram_en = 1'b1;
        busy    = 1'b1;
        addr_d  = row_ptr_q;
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (wcnt_q == WcW'(MEM_LATENCY - 1)) begin
          row_buf_d = bram_rdata;
          idx_d     = '0;
          state_d   = StShift;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StShift: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == IdxW'(DESIGN_SIZE - 1)) begin
            idx_d       = '0;
            drained_d   = drained_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            row_ptr_d   = row_ptr_q + 1'b1;  // wraps modulo 2^AWIDTH
            state_d     = (remaining_q == AWIDTH'(1)) ? StDone : StReq;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address is live during the request cycle and parked on the last request otherwise.
  assign bram_addr    = (state_q == StReq) ? row_ptr_q : addr_q;
  assign out_data     = (state_q == StShift) ? row_buf_q[int'(idx_q) * 8 +: 8] : 8'h00;
  assign rows_drained = drained_q;

endmodule

// File: tb/tb_bram_result_drain.sv
// Bench for bram_result_drain: table-driven and randomized drains against a
// byte-stream model of the BRAM contents, plus stall, ignored-start and reset cases.
module tb_bram_result_drain;

  localparam int DS = 32;
  localparam int AW = 11;
  localparam int NROWS_MEM = 2048;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_rows = '0;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [DS*8-1:0] bram_rdata = '0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [AW-1:0] rows_drained;

  bram_result_drain #(
    .DWIDTH(8), .DESIGN_SIZE(DS), .AWIDTH(AW), .MEM_LATENCY(1)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_rdata(bram_rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .rows_drained(rows_drained)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_lat = 0;
  int done_cnt = 0;
  bit rnd_ready = 1'b0;
  bit stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  logic [7:0] got_q[$];
  int addr_q[$];

  function automatic logic [7:0] mem_byte(int a, int b);
    return 8'(((a * 7) + (b * 29) + ((a >> 3) * 13)) ^ 8'h5A);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read BRAM with one cycle of latency.
  always @(posedge clk) begin
    if (bram_en)
      for (int b = 0; b < DS; b++) bram_rdata[b*8 +: 8] <= mem_byte(int'(bram_addr), b);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (bram_en) addr_q.push_back(int'(bram_addr));
      if (done) done_cnt++;
      if (stall_prev) begin
        total++;
        if (!out_valid || out_data !== stall_data) begin
          bad++;
          $display("FAIL stall_hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                   out_valid, out_data, stall_data);
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) got_q.push_back(out_data);
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic kick(input int base, input int rows);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(base);
    num_rows = AW'(rows);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    last_lat = cyc - start_cyc;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic check_result(input int base, input int rows, input int exp_lat);
    int exp_addr[$];
    logic [7:0] exp_b[$];
    int mism = -1;
    for (int r = 0; r < rows; r++) begin
      exp_addr.push_back((base + r) % NROWS_MEM);
      for (int b = 0; b < DS; b++) exp_b.push_back(mem_byte((base + r) % NROWS_MEM, b));
    end
    if (exp_lat >= 0) chk("done_latency", last_lat, exp_lat);
    chk("done_pulses", done_cnt, 1);
    chk("req_count", addr_q.size(), rows);
    for (int i = 0; i < addr_q.size() && i < rows; i++)
      if (addr_q[i] != exp_addr[i] && mism < 0) mism = i;
    if (mism >= 0) chk("req_addr", addr_q[mism], exp_addr[mism]);
    chk("byte_count", got_q.size(), rows * DS);
    mism = -1;
    for (int i = 0; i < got_q.size() && i < exp_b.size(); i++)
      if (got_q[i] !== exp_b[i] && mism < 0) mism = i;
    if (rows > 0) chk("byte_data", (mism < 0) ? 0 : int'(got_q[mism]),
                      (mism < 0) ? 0 : int'(exp_b[mism]));
    chk("rows_drained", int'(rows_drained), rows);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_bram_addr", int'(bram_addr), 0);
    chk("rst_bram_en", int'(bram_en), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rows_drained", int'(rows_drained), 0);
  endtask

  typedef struct {
    int base;
    int rows;
    bit rnd;
    int lat;  // -1: not checked (random backpressure)
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit seen;
    vecs[0] = '{base: 5,    rows: 1, rnd: 1'b0, lat: 35};
    vecs[1] = '{base: 0,    rows: 0, rnd: 1'b0, lat: 1};
    vecs[2] = '{base: 2047, rows: 3, rnd: 1'b0, lat: 103};
    vecs[3] = '{base: 100,  rows: 2, rnd: 1'b1, lat: -1};
    vecs[4] = '{base: 2046, rows: 2, rnd: 1'b0, lat: 69};
    vecs[5] = '{base: 777,  rows: 1, rnd: 1'b1, lat: -1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      clear_mon();
      rnd_ready = vecs[i].rnd;
      kick(vecs[i].base, vecs[i].rows);
      wait_done(2000);
      @(negedge clk);
      check_result(vecs[i].base, vecs[i].rows, vecs[i].lat);
    end

    for (int i = 0; i < 6; i++) begin
      int b = $urandom_range(0, 2047);
      int r = $urandom_range(0, 3);
      bit rr = 1'($urandom % 2);
      @(negedge clk);
      clear_mon();
      rnd_ready = rr;
      kick(b, r);
      wait_done(2000);
      @(negedge clk);
      check_result(b, r, rr ? -1 : ((r == 0) ? 1 : 1 + 34 * r));
    end

    // Start during SHIFT and during DONE must both be ignored.
    rnd_ready = 1'b0;
    @(negedge clk);
    clear_mon();
    kick(10, 1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    base_addr = AW'(500);
    num_rows = AW'(3);
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    start = 1'b1;
    base_addr = AW'(900);
    num_rows = AW'(1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_result(10, 1, 35);

    // Asynchronous reset in the middle of row 0.
    @(negedge clk);
    clear_mon();
    kick(300, 2);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (got_q.size() >= 10) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_byte10", int'(seen), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    resetn = 1'b1;
    @(negedge clk);
    clear_mon();
    kick(700, 1);
    wait_done(200);
    @(negedge clk);
    check_result(700, 1, 35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
